// File: rtl/instr_fetch_decode.sv
// rtl/instr_fetch_decode.sv - RV32I fetch/pre-decode stage, optional misaligned-target trap under FETCH_MISALIGN_TRAP_EN
module instr_fetch_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        r_type,
    output logic        i_type,
    output logic        load,
    output logic        store,
    output logic        branch,
    output logic        jal,
    output logic        jalr,
    output logic        lui,
    output logic        auipc,
    output logic [2:0]  fun3,
    output logic        fun7,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic        illegal
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
`ifdef FETCH_MISALIGN_TRAP_EN
        , ST_TRAP = 2'd3
`endif
    } state_t;

    state_t state;

    logic dec_r, dec_i, dec_load, dec_store, dec_branch;
    logic dec_jal, dec_jalr, dec_lui, dec_auipc, dec_illegal;
    logic        redirect;
    logic [31:0] tgt_clr;
    logic [31:0] tgt_eff;
    logic [31:0] next_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        trap_hit;
`endif

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    // Raw opcode decode of the instruction register, before valid gating
    always_comb begin
        dec_r       = 1'b0;
        dec_i       = 1'b0;
        dec_load    = 1'b0;
        dec_store   = 1'b0;
        dec_branch  = 1'b0;
        dec_jal     = 1'b0;
        dec_jalr    = 1'b0;
        dec_lui     = 1'b0;
        dec_auipc   = 1'b0;
        dec_illegal = 1'b0;
        case (instr[6:0])
            7'b0110011: dec_r       = 1'b1;
            7'b0010011: dec_i       = 1'b1;
            7'b0000011: dec_load    = 1'b1;
            7'b0100011: dec_store   = 1'b1;
            7'b1100011: dec_branch  = 1'b1;
            7'b1101111: dec_jal     = 1'b1;
            7'b1100111: dec_jalr    = 1'b1;
            7'b0110111: dec_lui     = 1'b1;
            7'b0010111: dec_auipc   = 1'b1;
            default:    dec_illegal = 1'b1;
        endcase
    end

    // Gated class flags; nothing downstream may fire outside EXEC
    always_comb begin
        r_type  = instr_valid & dec_r;
        i_type  = instr_valid & dec_i;
        load    = instr_valid & dec_load;
        store   = instr_valid & dec_store;
        branch  = instr_valid & dec_branch;
        jal     = instr_valid & dec_jal;
        jalr    = instr_valid & dec_jalr;
        lui     = instr_valid & dec_lui;
        auipc   = instr_valid & dec_auipc;
        illegal = instr_valid & dec_illegal;
        fun3    = instr_valid ? instr[14:12] : 3'b000;
        // bit 30 is only an opcode qualifier for R-type and the shift-right immediates
        fun7    = instr_valid & instr[30] &
                  (dec_r | (dec_i & (instr[14:12] == 3'b101)));
    end

    // Redirect target and next PC selection
    always_comb begin
        redirect = dec_jal | dec_jalr | (dec_branch & br_taken);
        tgt_clr  = {target[31:1], target[0] & ~dec_jalr};
`ifdef FETCH_MISALIGN_TRAP_EN
        tgt_eff  = tgt_clr;
        trap_hit = redirect & (tgt_eff[1:0] != 2'b00);
`else
        tgt_eff  = tgt_clr & ~32'h0000_0003;
`endif
        next_pc  = redirect ? tgt_eff : pc_plus4;
    end

    // Fetch/execute sequencer with registered handshake outputs and PC
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            instr       <= NOP;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_valid) begin
                        instr       <= imem_rdata;
                        state       <= ST_EXEC;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (trap_hit) begin
                            state    <= ST_TRAP;
                            misalign <= 1'b1;
                        end else begin
`endif
                            pc       <= next_pc;
                            state    <= ST_FETCH;
                            imem_req <= 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
                        end
`endif
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                ST_TRAP: begin
                    state <= ST_TRAP;
                end
`endif
                default: begin
                    state       <= ST_IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb/tb_instr_fetch_decode.sv - scoreboard bench for instr_fetch_decode
module tb_instr_fetch_decode;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        br_taken;
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        instr_valid;
    logic        r_type, i_type, load, store, branch, jal, jalr, lui, auipc;
    logic [2:0]  fun3;
    logic        fun7;
    logic        illegal;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    instr_fetch_decode #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .stall(stall), .br_taken(br_taken), .target(target),
        .pc(pc), .pc_plus4(pc_plus4), .instr(instr), .instr_valid(instr_valid),
        .r_type(r_type), .i_type(i_type), .load(load), .store(store),
        .branch(branch), .jal(jal), .jalr(jalr), .lui(lui), .auipc(auipc),
        .fun3(fun3), .fun7(fun7),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misalign(misalign),
`endif
        .illegal(illegal)
    );

    typedef struct {
        logic [8:0] flags;
        logic       ill;
        logic [2:0] f3;
        logic       f7;
    } exp_t;

    logic [31:0] exp_addr[$];
    exp_t        exp_dec[$];
    int          compares = 0;
    int          errors   = 0;
    int          cyc      = 0;
    logic [6:0]  op_tab [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    logic [8:0]  dut_flags;

    assign dut_flags = {r_type, i_type, load, store, branch, jal, jalr, lui, auipc};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    function automatic exp_t model_dec(input logic [31:0] w);
        exp_t e;
        e.flags = '0;
        for (int i = 0; i < 9; i++)
            if (w[6:0] == op_tab[i]) e.flags[8-i] = 1'b1;
        e.ill = (e.flags == 9'd0);
        e.f3  = w[14:12];
        e.f7  = (e.flags[8] || (e.flags[7] && w[14:12] == 3'b101)) ? w[30] : 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] w,
                                               input logic br, input logic [31:0] tgt);
        logic [31:0] t;
        t = tgt;
        if (w[6:0] == 7'b1100111) t[0] = 1'b0;
`ifndef FETCH_MISALIGN_TRAP_EN
        t[1:0] = 2'b00;
`endif
        if (w[6:0] == 7'b1101111 || w[6:0] == 7'b1100111 || (w[6:0] == 7'b1100011 && br))
            return t;
        return cur + 32'd4;
    endfunction

    // One fetch/execute transaction, entered at a negedge while the DUT is in FETCH
    task automatic do_instr(input logic [31:0] word, input int delay, input int stalls,
                            input logic br, input logic [31:0] tgt);
        logic [31:0] ea;
        exp_t        e;
        int          vcnt;
        ea = exp_addr.pop_front();
        compares++;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL fetch_req got %b required 1", imem_req); end
        compares++;
        if (imem_addr !== ea) begin errors++; $display("FAIL fetch_addr got %h required %h", imem_addr, ea); end
        compares++;
        if (dut_flags !== 9'd0 || illegal !== 1'b0) begin
            errors++; $display("FAIL gate_in_fetch got flags %b ill %b required 0", dut_flags, illegal);
        end
        for (int d = 0; d < delay; d++) begin
            imem_valid = 1'b0;
            imem_rdata = $urandom;
            tick;
            compares++;
            if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin
                errors++; $display("FAIL fetch_wait got req %b iv %b required 1 0", imem_req, instr_valid);
            end
        end
        imem_valid = 1'b1;
        imem_rdata = word;
        exp_dec.push_back(model_dec(word));
        tick;
        imem_valid = 1'b0;
        imem_rdata = $urandom;
        e = exp_dec.pop_front();
        vcnt = 0;
        while (instr_valid === 1'b1 && vcnt < 20) begin
            if (vcnt == 0) begin
                compares++;
                if (dut_flags !== e.flags || illegal !== e.ill) begin
                    errors++; $display("FAIL decode_flags word %h got %b/%b required %b/%b",
                                       word, dut_flags, illegal, e.flags, e.ill);
                end
                compares++;
                if (fun3 !== e.f3 || fun7 !== e.f7) begin
                    errors++; $display("FAIL decode_fun word %h got %b/%b required %b/%b",
                                       word, fun3, fun7, e.f3, e.f7);
                end
                compares++;
                if (instr !== word) begin errors++; $display("FAIL instr_reg got %h required %h", instr, word); end
            end
            compares++;
            if (pc !== ea || pc_plus4 !== ea + 32'd4) begin
                errors++; $display("FAIL pc_hold got %h/%h required %h", pc, pc_plus4, ea);
            end
            if (vcnt < stalls) begin
                stall    = 1'b1;
                br_taken = ~br;
                target   = $urandom;
            end else begin
                stall    = 1'b0;
                br_taken = br;
                target   = tgt;
                if (vcnt == stalls) exp_addr.push_back(model_next(ea, word, br, tgt));
            end
            vcnt++;
            tick;
        end
        stall    = 1'b0;
        br_taken = 1'b0;
        compares++;
        if (vcnt !== stalls + 1) begin
            errors++; $display("FAIL exec_cycles got %0d required %0d", vcnt, stalls + 1);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; imem_valid = 1'b0; imem_rdata = '0; stall = 1'b0; br_taken = 1'b0; target = '0;
        tick; tick;
        compares++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL reset_hs got %b %b required 0 0", imem_req, instr_valid);
        end
        compares++;
        if (pc !== 32'h100 || pc_plus4 !== 32'h104 || instr !== 32'h13) begin
            errors++; $display("FAIL reset_regs got %h %h %h required 100 104 13", pc, pc_plus4, instr);
        end
        compares++;
        if (dut_flags !== 9'd0 || fun3 !== 3'd0 || fun7 !== 1'b0 || illegal !== 1'b0) begin
            errors++; $display("FAIL reset_flags got %b %b %b %b required 0", dut_flags, fun3, fun7, illegal);
        end
        rst = 1'b1;
        tick;
        exp_addr.push_back(32'h100);
    endtask

    task automatic test_sequential;
        int c0;
        c0 = cyc;
        do_instr(32'h0010_0093, 0, 0, 1'b0, 32'h0);
        do_instr(32'h0020_0113, 0, 0, 1'b0, 32'h0);
        do_instr(32'h0030_0193, 0, 0, 1'b0, 32'h0);
        compares++;
        if (cyc - c0 !== 6) begin errors++; $display("FAIL throughput got %0d cycles required 6", cyc - c0); end
    endtask

    task automatic test_decode;
        do_instr(32'hFFF0_0093, 0, 0, 1'b1, 32'h0000_0AA0);
        do_instr(32'h4010_D093, 0, 0, 1'b0, 32'h0);
        do_instr(32'h4020_80B3, 1, 0, 1'b0, 32'h0);
        do_instr(32'h0000_A083, 0, 0, 1'b0, 32'h0);
        do_instr(32'h0010_A023, 0, 0, 1'b0, 32'h0);
        do_instr(32'h1234_50B7, 0, 0, 1'b0, 32'h0);
        do_instr(32'h0000_1097, 0, 0, 1'b0, 32'h0);
    endtask

    task automatic test_branch;
        do_instr(32'h0000_006F, 0, 0, 1'b0, 32'h0000_0200);
        do_instr(32'h0000_0063, 0, 0, 1'b1, 32'h0000_01F0);
        do_instr(32'h0000_006F, 0, 0, 1'b0, 32'h0000_0200);
        do_instr(32'h0000_0063, 0, 0, 1'b0, 32'h0000_01F0);
    endtask

    task automatic test_stall;
        do_instr(32'h0010_0093, 3, 2, 1'b0, 32'h0);
    endtask

    task automatic test_illegal;
        do_instr(32'h0000_007F, 0, 0, 1'b1, 32'h0000_0500);
    endtask

    task automatic test_wrap;
        do_instr(32'h0000_006F, 0, 0, 1'b0, 32'hFFFF_FFFC);
        do_instr(32'h0010_0093, 0, 1, 1'b0, 32'h0);
    endtask

    task automatic test_misalign;
        do_instr(32'h0000_8067, 0, 0, 1'b0, 32'h0000_0302);
`ifdef FETCH_MISALIGN_TRAP_EN
        void'(exp_addr.pop_front());
        for (int i = 0; i < 4; i++) begin
            compares++;
            if (misalign !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h0 || dut_flags !== 9'd0) begin
                errors++; $display("FAIL trap_hold got mis %b req %b pc %h required 1 0 0", misalign, imem_req, pc);
            end
            imem_valid = 1'b1;
            tick;
        end
        imem_valid = 1'b0;
`else
        do_instr(32'h0010_0093, 0, 0, 1'b0, 32'h0);
`endif
    endtask

    task automatic test_reset_mid;
        imem_valid = 1'b0;
        tick;
        #3;
        rst = 1'b0;
        #1;
        compares++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h100 || instr !== 32'h13) begin
            errors++; $display("FAIL async_reset got req %b iv %b pc %h instr %h required 0 0 100 13",
                               imem_req, instr_valid, pc, instr);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        compares++;
        if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b required 0", misalign); end
`endif
        imem_valid = 1'b1;
        imem_rdata = 32'h0000_006F;
        tick;
        rst = 1'b1;
        tick;
        compares++;
        if (imem_req !== 1'b1 || instr_valid !== 1'b0 || instr !== 32'h13) begin
            errors++; $display("FAIL late_valid got req %b iv %b instr %h required 1 0 13",
                               imem_req, instr_valid, instr);
        end
        exp_addr.delete();
        exp_addr.push_back(32'h100);
        do_instr(32'h0050_0293, 0, 0, 1'b0, 32'h0);
        do_instr(32'h0060_0313, 0, 0, 1'b0, 32'h0);
        void'(exp_addr.pop_front());
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_decode;
        test_branch;
        test_stall;
        test_illegal;
        test_wrap;
        test_misalign;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Instruction fetch and pre-decode stage that sits directly upstream of the control decoder in the RV32I core. It owns the program counter and runs a request/valid handshake with instruction memory. It holds the fetched word in an instruction register and produces the one-hot instruction-class flags plus `fun3`/`fun7` that the control decoder consumes. It also computes the next PC from the branch/jump outcome returned by the execute datapath.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address; equals `pc`.
- `imem_valid`  in  1  instruction memory returns a word this cycle.
- `imem_rdata`  in  32  returned instruction word.
- `stall`  in  1  holds the current instruction in EXEC.
- `br_taken`  in  1  branch comparison result from the datapath.
- `target`  in  32  jump/branch target from the ALU.
- `pc`, `pc_plus4`  out  32  current PC and PC+4.
- `instr`  out  32  instruction register.
- `instr_valid`  out  1  `instr` is executing this cycle.
- `r_type`, `i_type`, `load`, `store`, `branch`, `jal`, `jalr`, `lui`, `auipc`  out  1 each  one-hot class flags.
- `fun3`  out  3  `instr[14:12]`.
- `fun7`  out  1  function-7 qualifier.
- `illegal`  out  1  unknown opcode.
- `misalign`  out  1  misaligned target trap; present only with the macro described under Configuration.

## Operation
- FSM states and transitions:
  - IDLE: entered on reset; moves to FETCH after 1 cycle.
  - FETCH: `imem_req`=1. Stays until `imem_valid`=1, then captures `imem_rdata` into `instr` and moves to EXEC.
  - EXEC: `instr_valid`=1.
    - If `stall`=1, stays in EXEC and `pc` holds.
    - Otherwise updates `pc` to `next_pc` and moves to FETCH.
  - TRAP: present only with the macro. Terminal state with all outputs quiescent; exits only on reset.
- Next-PC rules:
  - `jal`, `jalr`, or (`branch` & `br_taken`): `next_pc = target`.
  - For `jalr`, bit 0 of `target` is cleared.
  - Otherwise: `next_pc = pc + 4`, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Opcode decode on `instr[6:0]`:
  - 0110011 → `r_type`
  - 0010011 → `i_type`
  - 0000011 → `load`
  - 0100011 → `store`
  - 1100011 → `branch`
  - 1101111 → `jal`
  - 1100111 → `jalr`
  - 0110111 → `lui`
  - 0010111 → `auipc`
  - Any other opcode → `illegal`=1 with all class flags 0. An illegal instruction advances by PC+4.
- `fun7` rules:
  - `r_type`: `fun7 = instr[30]`.
  - `i_type`: `fun7 = instr[30]` only when `fun3`=101, otherwise 0. This keeps immediates with bit 30 set from being misdecoded.
  - All other classes: `fun7` = 0.
- Gating: class flags and `illegal` are forced to 0 whenever `instr_valid`=0, so downstream writes cannot fire during fetch.
- `imem_valid` outside FETCH is ignored.
- `stall` outside EXEC is ignored.

## Timing
- Reset values:
  - state IDLE, `pc`=`RESET_PC`, `pc_plus4`=`RESET_PC`+4.
  - `instr`=32'h0000_0013 (NOP).
  - `imem_req`=0, `instr_valid`=0.
  - All flags, `fun3`, `fun7`, `illegal`, `misalign` = 0.
- Reset mid-operation asynchronously returns every output to its reset value, including while in FETCH with a request outstanding. A late `imem_valid` after reset is ignored until the next FETCH.
- Minimum throughput is one instruction per 2 cycles (FETCH with `imem_valid` on its first cycle, then EXEC).
- Each FETCH wait cycle adds 1 cycle.
- Each `stall` cycle extends EXEC by 1 cycle.
- `br_taken` and `target` are sampled on the EXEC exit edge only.
- `pc` changes on the same edge that leaves EXEC. `imem_addr` shows the new PC in the next FETCH cycle.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A taken redirect whose target has `[1:0]` ≠ 0 (after the `jalr` bit-0 clear) sets `misalign`=1 and enters TRAP.
  - `pc` is not updated; `misalign` stays 1 until reset.
- `FETCH_MISALIGN_TRAP_EN` undefined:
  - `target[1:0]` is forced to 00.
  - The `misalign` port and the TRAP state are absent.

## Test plan
- Reset release with `RESET_PC`=32'h100 and `imem_valid` tied high:
  - `imem_req` rises on cycle 2 with `imem_addr`=32'h100.
  - Sequential addi words retire every 2 cycles at 0x100, 0x104, 0x108.
- addi with negative immediate (word 32'hFFF00093):
  - `i_type`=1, `fun3`=000, `fun7`=0.
- srai (word 32'h4010D093):
  - `fun7`=1.
- beq at 0x200 with `br_taken`=1 and `target`=32'h1F0:
  - Next `imem_addr`=32'h1F0.
- Same beq at 0x200 with `br_taken`=0:
  - Next `imem_addr`=32'h204.
- `imem_valid` delayed 3 cycles, then `stall`=1 for 2 EXEC cycles:
  - `instr_valid` is high for exactly 3 cycles.
  - `pc` holds throughout.
- Opcode 1111111:
  - `illegal`=1, all class flags 0, next PC = PC+4.
- With the macro, `jalr` with `target`=32'h302:
  - `misalign`=1 and `imem_req` stays 0 until reset.
- Without the macro, same stimulus:
  - Fetch proceeds at 32'h300.
